uart_rx_fifo: RTL

//   Receive buffer directly downstream of the UART receiver. Captures each byte the receiver

---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver/control unit and the receive FIFO.
// master drives receive strobes and pops; slave is the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              rxFim;
    logic [DATA_W-1:0] dadoRx;
    logic              pop;
    logic              limpaFlags;
    logic [DATA_W-1:0] dadoSaida;
    logic              dadoValido;
    logic              vazio;
    logic              cheio;
    logic [ADDR_W:0]   ocupacao;
    logic              overflow;
    logic              underflow;

    modport master (
        output rxFim, dadoRx, pop, limpaFlags,
        input  dadoSaida, dadoValido, vazio, cheio, ocupacao, overflow, underflow
    );

    modport slave (
        input  rxFim, dadoRx, pop, limpaFlags,
        output dadoSaida, dadoValido, vazio, cheio, ocupacao, overflow, underflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO capturing one byte per rxFim rising edge, with sticky overflow/underflow.
// Define UART_RX_FIFO_FWFT_EN for first-word fall-through reads; default is a 1-cycle registered read.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_d;
    logic [ADDR_W:0]   r_count, w_count_d;
    logic              r_vazio, w_vazio_d;
    logic              r_cheio, w_cheio_d;
    logic              r_rx_fim_d;
    logic              r_overflow, w_overflow_d;
    logic              r_underflow, w_underflow_d;
    logic              w_push, w_wr_en, w_rd_en;

    always_comb begin
        w_push  = bus.rxFim & ~r_rx_fim_d;
        // A pop on a full FIFO frees the slot the incoming byte needs.
        w_wr_en = w_push & (~r_cheio | bus.pop);
        w_rd_en = bus.pop & ~r_vazio;

        w_wr_ptr_d = w_wr_en ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
        w_rd_ptr_d = w_rd_en ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

        w_count_d = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_d = r_count + (ADDR_W+1)'(1);
            2'b01:   w_count_d = r_count - (ADDR_W+1)'(1);
            default: w_count_d = r_count;
        endcase
        w_vazio_d = (w_count_d == '0);
        w_cheio_d = (w_count_d == (ADDR_W+1)'(DEPTH));

        w_overflow_d  = (r_overflow & ~bus.limpaFlags) | (w_push & r_cheio & ~bus.pop);
        w_underflow_d = (r_underflow & ~bus.limpaFlags) | (bus.pop & r_vazio);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_vazio     <= 1'b1;
            r_cheio     <= 1'b0;
            r_rx_fim_d  <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_d;
            r_rd_ptr    <= w_rd_ptr_d;
            r_count     <= w_count_d;
            r_vazio     <= w_vazio_d;
            r_cheio     <= w_cheio_d;
            r_rx_fim_d  <= bus.rxFim;
            r_overflow  <= w_overflow_d;
            r_underflow <= w_underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.dadoRx;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign bus.dadoSaida  = r_mem[r_rd_ptr];
    assign bus.dadoValido = ~r_vazio;
`else
    logic [DATA_W-1:0] r_dado_saida;
    logic              r_dado_valido;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dado_saida  <= '0;
            r_dado_valido <= 1'b0;
        end else begin
            r_dado_valido <= w_rd_en;
            if (w_rd_en) begin
                r_dado_saida <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.dadoSaida  = r_dado_saida;
    assign bus.dadoValido = r_dado_valido;
`endif

    assign bus.vazio     = r_vazio;
    assign bus.cheio     = r_cheio;
    assign bus.ocupacao  = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
